// File: rtl/mips32_hazard_ctrl.sv
// Interlock and issue controller for the 5-stage MIPS32 pipeline: tracks in-flight
// destinations, stalls ID on RAW hazards, sequences branch flush and HLT drain/halt.
module mips32_hazard_ctrl #(
    parameter int unsigned WB_BYPASS = 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk1,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [31:0]      id_ir,
    input  logic             ex_taken,
    output logic             issue,
    output logic             stall,
    output logic             bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;

    assign opcode = id_ir[31:26];
    assign rs     = id_ir[25:21];
    assign rt     = id_ir[20:16];
    assign rd     = id_ir[15:11];

    // Immediate/funct bits carry no hazard information.
    logic unused_imm;
    assign unused_imm = ^id_ir[10:0];

    logic       rd_rs;
    logic       rd_rt;
    logic       has_dst;
    logic [4:0] dst;
    logic       id_hlt;
    logic       id_dst_v;

    always_comb begin
        rd_rs   = 1'b0;
        rd_rt   = 1'b0;
        has_dst = 1'b0;
        dst     = '0;
        id_hlt  = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: begin
                rd_rs   = 1'b1;
                rd_rt   = 1'b1;
                has_dst = 1'b1;
                dst     = rd;
            end
            OP_ADDI, OP_SUBI, OP_SLTI, OP_LW: begin
                rd_rs   = 1'b1;
                has_dst = 1'b1;
                dst     = rt;
            end
            OP_SW: begin
                rd_rs = 1'b1;
                rd_rt = 1'b1;
            end
            OP_BNEQZ, OP_BEQZ: begin
                rd_rs = 1'b1;
            end
            OP_HLT: begin
                id_hlt = 1'b1;
            end
            default: ;
        endcase
    end

    // Writes to R0 are architecturally discarded, so they never create a dependency.
    assign id_dst_v = has_dst && (dst != 5'd0);

    logic       ex_v,  mem_v,  wb_v;
    logic [4:0] ex_dest, mem_dest, wb_dest;
    logic       ex_hlt, mem_hlt, wb_hlt;

    logic       chk_wb;
    logic       rs_hit;
    logic       rt_hit;
    logic       hazard;

    assign chk_wb = (WB_BYPASS == 0);

    always_comb begin
        rs_hit = (rs != 5'd0) &&
                 ((ex_v  && (ex_dest  == rs)) ||
                  (mem_v && (mem_dest == rs)) ||
                  (chk_wb && wb_v && (wb_dest == rs)));
        rt_hit = (rt != 5'd0) &&
                 ((ex_v  && (ex_dest  == rt)) ||
                  (mem_v && (mem_dest == rt)) ||
                  (chk_wb && wb_v && (wb_dest == rt)));
        hazard = id_valid && ((rd_rs && rs_hit) || (rd_rt && rt_hit));
    end

    logic [1:0] state;
    logic       hz_stall;

    always_comb begin
        issue    = 1'b0;
        stall    = 1'b0;
        bubble   = 1'b1;
        hz_stall = 1'b0;
        case (state)
            ST_RUN: begin
                if (ex_taken) begin
                    issue = 1'b0;
                end else if (hazard) begin
                    stall    = 1'b1;
                    hz_stall = 1'b1;
                end else if (id_valid) begin
                    issue  = 1'b1;
                    bubble = 1'b0;
                end
            end
            ST_DRAIN, ST_HALT: begin
                stall = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            ex_v     <= 1'b0;
            ex_dest  <= '0;
            ex_hlt   <= 1'b0;
            mem_v    <= 1'b0;
            mem_dest <= '0;
            mem_hlt  <= 1'b0;
            wb_v     <= 1'b0;
            wb_dest  <= '0;
            wb_hlt   <= 1'b0;
        end else begin
            wb_v     <= mem_v;
            wb_dest  <= mem_dest;
            wb_hlt   <= mem_hlt;
            mem_v    <= ex_v;
            mem_dest <= ex_dest;
            mem_hlt  <= ex_hlt;
            ex_v     <= issue && id_dst_v;
            ex_dest  <= issue ? dst : 5'd0;
            ex_hlt   <= issue && id_hlt;
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_RUN;
            halted <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (issue && id_hlt) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (wb_hlt) begin
                        state  <= ST_HALT;
                        halted <= 1'b1;
                    end
                end
                ST_HALT: begin
                    halted <= 1'b1;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (hz_stall && (stall_count != '1)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: doc/mips32_hazard_ctrl.md
Name: mips32_hazard_ctrl

Overview:
- Interlock and issue controller for the 5-stage pipelined MIPS32 (IF, ID, EX, MEM, WB).
- Decodes the instruction held in ID and tracks the destination registers of instructions in flight in EX, MEM and WB.
- Stalls IF/ID on read-after-write hazards, which removes the need for dummy-instruction padding in programs.
- Also sequences branch flush, HLT drain and halt, and counts stall cycles.

Parameters:
- WB_BYPASS, 1: 1 = register file forwards a same-cycle WB write to the ID read, so the WB slot is excluded from hazard checks; 0 = the WB slot is also checked.
- CNT_W, 16: width of the stall counter.

Ports:
- clk1  input  1  pipeline clock; the single clock for this block.
- rst_n  input  1  asynchronous active-low reset.
- id_valid  input  1  ID holds a valid instruction.
- id_ir  input  32  instruction in ID: opcode [31:26], rs [25:21], rt [20:16], rd [15:11].
- ex_taken  input  1  branch in EX is taken this cycle.
- issue  output  1  advance ID into EX this cycle (ID/EX load enable).
- stall  output  1  hold PC and IF/ID this cycle.
- bubble  output  1  load a NOP into ID/EX this cycle.
- halted  output  1  HLT has retired; pipeline frozen.
- stall_count  output  CNT_W  cycles with stall=1 caused by hazards.

Behaviour:
- Decode classes:
  - RR ops (ADD 000000, SUB 000001, AND 000010, OR 000011, SLT 000100, MUL 000101): read rs and rt; destination rd.
  - ADDI 001010, SUBI 001011, SLTI 001100, LW 001000: read rs; destination rt.
  - SW 001001: reads rs and rt; no destination.
  - BNEQZ 001101, BEQZ 001110: read rs; no destination.
  - HLT 111111: no reads, no destination.
  - Any other opcode: treated as NOP, no reads, no destination.
  - A destination of R0 is recorded as no destination.
- Scoreboard: three registered slots EX, MEM, WB, each holding {v, dest[4:0], hlt}. Every cycle the slots shift: WB<=MEM, MEM<=EX. EX<= the decoded ID instruction if issue=1, otherwise a bubble (v=0, hlt=0).
- hazard (combinational): id_valid and some source register read by the ID instruction equals the dest of a valid EX or MEM slot. The WB slot is also checked when WB_BYPASS=0. Source R0 never hazards.
- FSM states: RUN, DRAIN, HALT. Reset state is RUN.
  - RUN:
    - If ex_taken: issue=0, bubble=1, stall=0. Flush has priority over hazard; the ID instruction is discarded and never issued.
    - Else if hazard: issue=0, bubble=1, stall=1, and stall_count increments.
    - Else if id_valid: issue=1, bubble=0, stall=0. If the instruction is HLT, set EX.hlt=1 and go to DRAIN.
    - Else (no valid instruction): issue=0, bubble=1, stall=0.
  - DRAIN: issue=0, bubble=1, stall=1. ex_taken is ignored. stall_count does not increment. Go to HALT in the cycle after the hlt flag reaches the WB slot.
  - HALT: issue=0, bubble=1, stall=1, halted=1. Leave only on reset.
- Outputs issue, stall and bubble are combinational from state, slots and inputs. halted is registered.
- stall_count saturates at all ones; it does not wrap.
- Reset, including mid-operation, asynchronously clears all slots, state=RUN, stall_count=0 and halted=0. Combinational outputs then read issue=id_valid&&!ex_taken, stall=0, bubble=!issue.
- Latency: an instruction issued at cycle N occupies EX at N+1, MEM at N+2 and WB at N+3. A dependent instruction stalls 2 cycles (WB_BYPASS=1) or 3 cycles (WB_BYPASS=0) when issued back-to-back.

Test Plan:
- Back-to-back ADDI R1,R0,120 (0x28010078) then LW R2,0(R1) (0x20220000), WB_BYPASS=1: LW sees stall=1 for exactly 2 cycles, then issue=1; stall_count=2.
- ADDI R1,R0,120 followed by OR R3,R3,R3 (0x0c631800): no stall, issue=1 on consecutive cycles, stall_count=0.
- ADDI R0,R0,5 followed by ADD R4,R0,R0: no stall (R0 destination ignored).
- WB_BYPASS=0, LW R2 then ADDI R2,R2,45 (0x2842002d): 3 stall cycles, then issue.
- Hazarded ID instruction with ex_taken=1 in the same cycle: issue=0, bubble=1, stall=0, stall_count unchanged.
- HLT (0xfc000000) issued at cycle N: stall=1 from N+1, halted=1 at N+4 and held; assert rst_n low mid-DRAIN -> halted=0, state RUN, all slots empty immediately.
